// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: op encoding, FSM states and
// the iteration-counter width helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OpMul  = 2'b00,
    OpMla  = 2'b01,
    OpSdiv = 2'b10,
    OpUdiv = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // The counter has to hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Command/result bundle between the issuing datapath (master) and muldiv_unit (slave).
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  import muldiv_pkg::*;

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, c,
    input  ready, done, result, div_by_zero
  );

  modport slave (
    input  start, op, a, b, c,
    output ready, done, result, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // rem < divisor on entry, so the shifted value is < 2*divisor and trial's MSB is a
  // reliable borrow flag.
  always_comb begin
    trial    = {rem, dividend_bit} - {1'b0, divisor};
    q_bit    = ~trial[WIDTH];
    rem_next = q_bit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], dividend_bit};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MUL/MLA/SDIV/UDIV engine with a start/ready/done handshake.
// Define MULDIV_MLA_EN to build the c addend path for MLA; otherwise MLA behaves as MUL.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  muldiv_if.slave  bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             dbz_q, dbz_d;
  logic             ready_q;
  logic             done_q;
`ifdef MULDIV_MLA_EN
  logic [WIDTH-1:0] c_q, c_d;
`endif

  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             op_is_div;

  // acc_q doubles as product accumulator and division remainder; a_q collects quotient bits.
  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem         (acc_q),
    .dividend_bit(a_q[WIDTH-1]),
    .divisor     (b_q),
    .rem_next    (rem_next),
    .q_bit       (q_bit)
  );

  always_comb begin
    a_mag     = bus.a[WIDTH-1] ? ('0 - bus.a) : bus.a;
    b_mag     = bus.b[WIDTH-1] ? ('0 - bus.b) : bus.b;
    op_is_div = (op_q == OpSdiv) || (op_q == OpUdiv);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    dbz_d    = dbz_q;
`ifdef MULDIV_MLA_EN
    c_d      = c_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d  = bus.op;
          a_d   = bus.a;
          b_d   = bus.b;
          acc_d = '0;
          cnt_d = '0;
          neg_d = 1'b0;
`ifdef MULDIV_MLA_EN
          c_d   = bus.c;
`endif
          if ((bus.op == OpSdiv || bus.op == OpUdiv) && bus.b == '0) begin
            state_d  = StDone;
            result_d = '0;
            dbz_d    = 1'b1;
          end else begin
            state_d = StRun;
            if (bus.op == OpSdiv) begin
              a_d   = a_mag;
              b_d   = b_mag;
              neg_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            end
          end
        end
      end

      StRun: begin
        if (cnt_q == CntW'(WIDTH)) begin
          state_d = StDone;
          dbz_d   = 1'b0;
          case (op_q)
            OpSdiv:  result_d = neg_q ? ('0 - a_q) : a_q;
            OpUdiv:  result_d = a_q;
`ifdef MULDIV_MLA_EN
            OpMla:   result_d = acc_q + c_q;
`endif
            default: result_d = acc_q;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (op_is_div) begin
            acc_d = rem_next;
            a_d   = {a_q[WIDTH-2:0], q_bit};
          end else begin
            acc_d = acc_q + (b_q[0] ? a_q : '0);
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
          end
        end
      end

      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      dbz_q    <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
`ifdef MULDIV_MLA_EN
      c_q      <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      dbz_q    <= dbz_d;
      ready_q  <= (state_d == StIdle);
      done_q   <= (state_d == StDone);
`ifdef MULDIV_MLA_EN
      c_q      <= c_d;
`endif
    end
  end

  assign bus.ready       = ready_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at WIDTH=32; MLA expectation follows MULDIV_MLA_EN.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one command, optionally re-pulses start at RUN cycle poke_at, and waits for done.
  // lat counts rising edges after the accept edge before done is seen.
  task automatic run_op(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input int poke_at,
                        output logic [W-1:0] res, output logic dbz, output int lat,
                        output logic rdy_low);
    int guard = 0;
    @(negedge clk);
    while (!bus.ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.ready) check("ready_wait", 64'(bus.ready), 64'd1);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.c     = c;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = op_e'(2'($urandom));
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.c     = $urandom;
    lat       = 0;
    rdy_low   = 1'b1;
    while (!bus.done && lat < 200) begin
      if (bus.ready) rdy_low = 1'b0;
      bus.start = (lat == poke_at);
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    if (bus.ready) rdy_low = 1'b0;
    if (!bus.done) check("done_timeout", 64'(bus.done), 64'd1);
    res = bus.result;
    dbz = bus.div_by_zero;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] res;
    logic         dbz;
    logic         rdy_low;
    int           lat;
    int           dones;

    bus.start = 1'b0;
    bus.op    = OpMul;
    bus.a     = '0;
    bus.b     = '0;
    bus.c     = '0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_dbz", 64'(bus.div_by_zero), 64'd0);

    run_op(OpUdiv, 32'd100, 32'd7, 32'd0, -1, res, dbz, lat, rdy_low);
    check("udiv_100_7", 64'(res), 64'd14);
    check("udiv_100_7_dbz", 64'(dbz), 64'd0);
    check("udiv_100_7_lat", 64'(lat), 64'd33);
    check("udiv_100_7_ready_low", 64'(rdy_low), 64'd1);
    @(negedge clk);
    check("udiv_hold_result", 64'(bus.result), 64'd14);
    check("udiv_done_pulse", 64'(bus.done), 64'd0);
    check("udiv_ready_back", 64'(bus.ready), 64'd1);

    run_op(OpSdiv, 32'hFFFF_FF9C, 32'd7, 32'd0, -1, res, dbz, lat, rdy_low);
    check("sdiv_m100_7", 64'(res), 64'hFFFF_FFF2);
    run_op(OpSdiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, -1, res, dbz, lat, rdy_low);
    check("sdiv_min_m1", 64'(res), 64'h8000_0000);
    check("sdiv_min_m1_dbz", 64'(dbz), 64'd0);
    run_op(OpSdiv, 32'd7, 32'hFFFF_FFFE, 32'd0, -1, res, dbz, lat, rdy_low);
    check("sdiv_7_m2", 64'(res), 64'hFFFF_FFFD);
    run_op(OpSdiv, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd0, -1, res, dbz, lat, rdy_low);
    check("sdiv_m100_m7", 64'(res), 64'd14);

    run_op(OpMla, 32'd6, 32'd7, 32'd10, -1, res, dbz, lat, rdy_low);
`ifdef MULDIV_MLA_EN
    check("mla_6_7_10", 64'(res), 64'd52);
`else
    check("mla_6_7_10", 64'(res), 64'd42);
`endif
    check("mla_lat", 64'(lat), 64'd33);

    run_op(OpUdiv, 32'd5, 32'd0, 32'd0, -1, res, dbz, lat, rdy_low);
    check("udiv_by_zero_result", 64'(res), 64'd0);
    check("udiv_by_zero_flag", 64'(dbz), 64'd1);
    check("udiv_by_zero_lat", 64'(lat), 64'd0);
    run_op(OpUdiv, 32'd9, 32'd3, 32'd0, -1, res, dbz, lat, rdy_low);
    check("udiv_9_3", 64'(res), 64'd3);
    check("udiv_9_3_dbz", 64'(dbz), 64'd0);

    run_op(OpMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5, res, dbz, lat, rdy_low);
    check("mul_ones", 64'(res), 64'd1);
    check("mul_ones_lat", 64'(lat), 64'd33);
    dones = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("mul_poke_extra_done", 64'(dones), 64'd0);
    check("mul_poke_ready", 64'(bus.ready), 64'd1);

    run_op(OpMul, 32'h0001_0000, 32'h0001_0000, 32'd0, -1, res, dbz, lat, rdy_low);
    check("mul_wrap", 64'(res), 64'd0);
    run_op(OpMul, 32'd5, 32'd0, 32'd0, -1, res, dbz, lat, rdy_low);
    check("mul_b0", 64'(res), 64'd0);
    check("mul_b0_lat", 64'(lat), 64'd33);
    run_op(OpUdiv, 32'd7, 32'd100, 32'd0, -1, res, dbz, lat, rdy_low);
    check("udiv_7_100", 64'(res), 64'd0);
    run_op(OpMul, 32'h0000_1234, 32'h0000_0010, 32'd0, -1, res, dbz, lat, rdy_low);
    check("mul_1234_10", 64'(res), 64'h0001_2340);

    // Abort a UDIV with a one-edge reset at RUN cycle 10.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OpUdiv;
    bus.a     = 32'd1000;
    bus.b     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", 64'(bus.ready), 64'd1);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_result", 64'(bus.result), 64'd0);
    check("abort_dbz", 64'(bus.div_by_zero), 64'd0);
    dones = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    run_op(OpMul, 32'd3, 32'd4, 32'd0, -1, res, dbz, lat, rdy_low);
    check("mul_3_4_after_abort", 64'(res), 64'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
